i2c_codec_config_seq: RTL and testbench
=======================================

// Module: i2c_codec_config_seq
// PURPOSE
//  Parametrised I2C register-write sequencer for the board audio codec (WM8731-style 7b reg / 9b data).
//  Self-contained: internal SCL divider and bit engine, no external slow-clock module.
//  Walks an external init table after reset, then serves runtime register writes (volume, mute) via req/ack.
//  NACK handling, status, and a saturating NACK counter.
// PARAMETERS
//  CLK_FREQ_HZ  50_000_000  system clock frequency
//  I2C_FREQ_HZ  400_000     SCL frequency; quarter-tick DIV = CLK_FREQ_HZ/(4*I2C_FREQ_HZ), floor, min 1
//  DEV_ADDR     7'h1A       7-bit codec slave address
//  NUM_REGS     10          init table entries (1..2**ROM_AW)
//  ROM_AW       4           table address width
//  MAX_RETRY    3           extra attempts per frame on NACK (needs I2C_CFG_RETRY_EN)
// PORTS
//  clk        in   1        system clock
//  reset_n    in   1        asynchronous active-low reset
//  rom_addr   out  ROM_AW   init table index
//  rom_data   in   16       {reg[6:0], data[8:0]}, combinational, sampled in LOAD
//  wr_req     in   1        runtime write request, held until wr_ack
//  wr_reg     in   7        runtime register address
//  wr_data    in   9        runtime register data
//  wr_ack     out  1        1-cycle pulse: runtime frame finished (ACKed or abandoned)
//  init_done  out  1        all NUM_REGS entries sent; stays 1 until reset
//  busy       out  1        frame in progress
//  error      out  1        sticky; set when a frame is abandoned on NACK
//  nack_count out  8        NACKs seen, saturates at 8'hFF
//  I2C_SDAT   inout 1       open drain: drives 0 or Z only
//  I2C_SCLK   out  1        push-pull SCL
// BEHAVIOUR
//  Reset (async, reset_n=0): I2C_SCLK=1, I2C_SDAT=Z, rom_addr=0, wr_ack=0, init_done=0, busy=0, error=0, nack_count=0.
//  Reset mid-frame: bus released at once (no STOP); sequence restarts at entry 0.
//  SCL timing: quarter-tick counter of DIV cycles.
//  - Bit slot is 4 ticks: SDA changes in tick0 (SCL low), SCL high in ticks 1-2, low in tick3.
//  - START: SDA falls while SCL high. STOP: SDA rises while SCL high.
//  Frame: START, {DEV_ADDR,1'b0}, ACK, {reg,data[8]}, ACK, data[7:0], ACK, STOP. MSB first.
//  - 27 bit slots in total.
//  - ACK slots release SDA; sample at tick2: 0=ACK, 1=NACK.
//  - Any NACK aborts the remaining bytes; STOP is still sent.
//  FSM: IDLE -> LOAD -> START -> BITS -> ACK -> (BITS|STOP) -> GAP -> IDLE.
//  - GAP holds SCL=SDA=1 for 4 ticks (bus-free time).
//  - busy=1 from LOAD through GAP.
//  Scheduling:
//  - After reset, entries 0..NUM_REGS-1 are sent in order; rom_addr increments in GAP.
//  - init_done rises in the cycle after the last GAP.
//  - wr_req is ignored until init_done=1; once accepted it is latched in LOAD.
//  - wr_req must stay stable until wr_ack; wr_ack pulses in the cycle GAP exits.
//  - A new wr_req in the same cycle as wr_ack is taken as a new request.
//  nack_count increments once per NACK event, including retries; it holds at 255.
// CONFIGURATION
//  I2C_CFG_RETRY_EN defined:
//  - A NACKed frame is resent from START, after GAP, up to MAX_RETRY more times.
//  - After the final NACK, error=1 and the sequencer moves to the next entry (init) or issues wr_ack.
//  I2C_CFG_RETRY_EN undefined:
//  - MAX_RETRY is ignored; the first NACK sets error=1 and the sequencer advances at once.
// TESTING
//  Bench uses CLK_FREQ_HZ=1_600_000, I2C_FREQ_HZ=100_000 (DIV=4) and a slave model that ACKs address 7'h1A.
//  1) Reset release, NUM_REGS=2, table {16'h1E00,16'h0C00}
//     -> frames 34,1E,00 then 34,0C,00; init_done=1; error=0; nack_count=0.
//  2) After init, wr_req with reg=7'h02, data=9'h17B
//     -> bytes 34,05,7B; one wr_ack pulse; busy low afterwards.
//  3) RETRY_EN, MAX_RETRY=3, slave NACKs the first 2 attempts
//     -> 3 frames sent; nack_count=2; error=0.
//  4) Slave always NACKs
//     -> RETRY_EN: 4 attempts/entry; error=1; init still completes.
//     -> Without the macro: 1 attempt; error=1.
//  5) reset_n=0 during the 2nd byte
//     -> SCLK=1 and SDAT=Z in the same cycle; after release, table replays from entry 0.
//  6) wr_req asserted before init_done
//     -> no runtime frame until all table frames are done, then exactly one wr_ack.

Source files
------------

// File: rtl/i2c_codec_config_seq.sv
// i2c_codec_config_seq
// I2C register-write sequencer for a WM8731-style audio codec (7-bit register
// address, 9-bit data). After reset it walks an external init table, then
// serves runtime register writes through a wr_req/wr_ack handshake.
// SCL is generated internally from a quarter-tick down-counter.
//
// Build option:
//   I2C_CFG_RETRY_EN  when defined, a NACKed frame is resent up to MAX_RETRY
//                     more times before it is abandoned.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   rom_addr    init table index
//   rom_data    init table entry {reg[6:0], data[8:0]}, sampled in LOAD
//   wr_req      runtime write request, held until wr_ack
//   wr_reg      runtime register address
//   wr_data     runtime register data
//   wr_ack      1-cycle pulse when a runtime frame is finished
//   init_done   all init entries sent (held until reset)
//   busy        frame in progress (LOAD through GAP)
//   error       sticky, set when a frame is abandoned on NACK
//   nack_count  saturating count of NACKs seen
//   I2C_SDAT    open-drain data line (drives 0 or Z)
//   I2C_SCLK    push-pull clock line
//
// state | meaning
// IDLE  | bus free, choose next frame source (init table first, then wr_req)
// LOAD  | latch {addr+W, reg, data} into the shift register
// START | SDA falls while SCL high
// BITS  | shift out one data bit per 4-tick slot, MSB first
// ACK   | release SDA, sample slave response at tick 2
// STOP  | SDA rises while SCL high
// GAP   | bus-free time, then decide retry / advance
module i2c_codec_config_seq #(
   parameter int         CLK_FREQ_HZ = 50_000_000,
   parameter int         I2C_FREQ_HZ = 400_000,
   parameter logic [6:0] DEV_ADDR    = 7'h1A,
   parameter int         NUM_REGS    = 10,
   parameter int         ROM_AW      = 4,
   parameter int         MAX_RETRY   = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   input  logic              wr_req,
   input  logic [6:0]        wr_reg,
   input  logic [8:0]        wr_data,
   output logic              wr_ack,
   output logic              init_done,
   output logic              busy,
   output logic              error,
   output logic [7:0]        nack_count,
   inout  wire               I2C_SDAT,
   output logic              I2C_SCLK
);

   localparam int DIV_RAW = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0]     DIV_LOAD  = DW'(DIV - 1);
   localparam logic [ROM_AW-1:0] LAST_ADDR = ROM_AW'(NUM_REGS - 1);
`ifdef I2C_CFG_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_BITS  = 3'd3,
      S_ACK   = 3'd4,
      S_STOP  = 3'd5,
      S_GAP   = 3'd6
   } state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] div_cnt;
   logic [1:0]    qtr;
   logic [23:0]   shreg;
   logic [2:0]    bit_cnt;
   logic [1:0]    byte_idx;
   logic          is_rt;
   logic          nacked;
   logic [7:0]    retry_cnt;
   logic          scl_q, sda_low_q;
   logic          scl_nxt, sda_low_nxt;
   logic          tick, slot_end, ack_sample, frame_done, do_retry;
   logic          sda_in;

   assign sda_in     = I2C_SDAT;
   assign tick       = (div_cnt == '0);
   assign slot_end   = tick && (qtr == 2'd3);
   assign ack_sample = (state == S_ACK) && tick && (qtr == 2'd2);
   assign frame_done = (state == S_GAP) && slot_end;
   // retry_cnt never leaves 0 when retries are compiled out
   assign do_retry   = frame_done && nacked && RETRY_EN && (int'(retry_cnt) < MAX_RETRY);

   assign busy     = (state != S_IDLE);
   assign I2C_SCLK = scl_q;
   assign I2C_SDAT = sda_low_q ? 1'b0 : 1'bz;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      scl_nxt     = 1'b1;
      sda_low_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            if (!init_done || wr_req) state_nxt = S_LOAD;
         end
         S_LOAD: state_nxt = S_START;
         S_START: begin
            scl_nxt     = (qtr != 2'd3);
            sda_low_nxt = (qtr != 2'd0);
            if (slot_end) state_nxt = S_BITS;
         end
         S_BITS: begin
            scl_nxt     = (qtr == 2'd1) || (qtr == 2'd2);
            sda_low_nxt = !shreg[23];
            if (slot_end && bit_cnt == 3'd0) state_nxt = S_ACK;
         end
         S_ACK: begin
            scl_nxt = (qtr == 2'd1) || (qtr == 2'd2);
            if (slot_end) state_nxt = (nacked || byte_idx == 2'd2) ? S_STOP : S_BITS;
         end
         S_STOP: begin
            scl_nxt     = (qtr != 2'd0);
            sda_low_nxt = (qtr < 2'd2);
            if (slot_end) state_nxt = S_GAP;
         end
         S_GAP: begin
            if (slot_end) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Bus pins are registered so SCL/SDA never glitch on decode changes;
   // this delays the whole waveform by one clock uniformly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_q      <= 1'b1;
         sda_low_q  <= 1'b0;
         div_cnt    <= DIV_LOAD;
         qtr        <= 2'd0;
         shreg      <= '0;
         bit_cnt    <= 3'd7;
         byte_idx   <= 2'd0;
         is_rt      <= 1'b0;
         nacked     <= 1'b0;
         retry_cnt  <= 8'd0;
         rom_addr   <= '0;
         wr_ack     <= 1'b0;
         init_done  <= 1'b0;
         error      <= 1'b0;
         nack_count <= 8'd0;
      end else begin
         scl_q     <= scl_nxt;
         sda_low_q <= sda_low_nxt;
         wr_ack    <= 1'b0;

         if (state == S_IDLE || state == S_LOAD) begin
            div_cnt <= DIV_LOAD;
            qtr     <= 2'd0;
         end else if (tick) begin
            div_cnt <= DIV_LOAD;
            qtr     <= qtr + 2'd1;
         end else begin
            div_cnt <= div_cnt - 1'b1;
         end

         case (state)
            S_LOAD: begin
               if (init_done) shreg <= {DEV_ADDR, 1'b0, wr_reg, wr_data};
               else           shreg <= {DEV_ADDR, 1'b0, rom_data};
               is_rt    <= init_done;
               bit_cnt  <= 3'd7;
               byte_idx <= 2'd0;
               nacked   <= 1'b0;
            end
            S_BITS: begin
               if (slot_end) begin
                  shreg   <= {shreg[22:0], 1'b0};
                  bit_cnt <= bit_cnt - 3'd1;
               end
            end
            S_ACK: begin
               if (ack_sample && sda_in) begin
                  nacked <= 1'b1;
                  if (nack_count != 8'hFF) nack_count <= nack_count + 8'd1;
               end
               if (slot_end) byte_idx <= byte_idx + 2'd1;
            end
            S_GAP: begin
               if (do_retry) begin
                  retry_cnt <= retry_cnt + 8'd1;
               end else if (frame_done) begin
                  retry_cnt <= 8'd0;
                  if (nacked) error <= 1'b1;
                  if (is_rt)                       wr_ack    <= 1'b1;
                  else if (rom_addr == LAST_ADDR)  init_done <= 1'b1;
                  else                             rom_addr  <= rom_addr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_codec_config_seq.sv
module tb_i2c_codec_config_seq;
   localparam int NREG      = 2;
   localparam int MAX_RETRY = 3;
`ifdef I2C_CFG_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  rom_addr;
   logic [15:0] rom_data;
   logic [15:0] rom [16];
   logic        wr_req = 1'b0;
   logic [6:0]  wr_reg = 7'd0;
   logic [8:0]  wr_data = 9'd0;
   logic        wr_ack, init_done, busy, error;
   logic [7:0]  nack_count;
   wire         sdat;
   logic        sclk;
   logic        slave_low = 1'b0;

   int errors = 0;
   int checks = 0;

   assign sdat = slave_low ? 1'b0 : 1'bz;
   pullup (sdat);
   assign rom_data = rom[rom_addr];

   always #5 clk = ~clk;

   i2c_codec_config_seq #(
      .CLK_FREQ_HZ(1_600_000), .I2C_FREQ_HZ(100_000), .DEV_ADDR(7'h1A),
      .NUM_REGS(NREG), .ROM_AW(4), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk), .reset_n(reset_n), .rom_addr(rom_addr), .rom_data(rom_data),
      .wr_req(wr_req), .wr_reg(wr_reg), .wr_data(wr_data), .wr_ack(wr_ack),
      .init_done(init_done), .busy(busy), .error(error), .nack_count(nack_count),
      .I2C_SDAT(sdat), .I2C_SCLK(sclk)
   );

   // ---------------- slave model (samples the bus on the falling clk edge)
   logic [23:0] cap_q[$];
   int          capn_q[$];
   int          frames_started = 0;
   int          sl_nack_first = 0;
   bit          sl_nack_all = 1'b0;
   bit          slave_rst = 1'b0;
   int          bitn = 0, byte_i = 0;
   int          ack_cnt = 0;

   initial begin
      logic prev_scl, prev_sda, scl_v, sda_v, in_frame, ack_phase, nack;
      logic [7:0]  sh;
      logic [23:0] cur;
      prev_scl = 1'b1; prev_sda = 1'b1; in_frame = 1'b0; ack_phase = 1'b0;
      sh = 8'd0; cur = 24'd0;
      forever begin
         @(negedge clk);
         scl_v = sclk;
         sda_v = (sdat !== 1'b0);
         if (slave_rst) begin
            in_frame = 1'b0; ack_phase = 1'b0; slave_low = 1'b0; bitn = 0; byte_i = 0;
         end else if (scl_v && prev_scl && prev_sda && !sda_v) begin
            in_frame = 1'b1; ack_phase = 1'b0; bitn = 0; byte_i = 0; cur = 24'd0;
            frames_started++;
         end else if (scl_v && prev_scl && !prev_sda && sda_v) begin
            if (in_frame) begin
               cap_q.push_back(cur);
               capn_q.push_back(byte_i);
            end
            in_frame = 1'b0;
         end else if (in_frame && scl_v && !prev_scl) begin
            if (!ack_phase) begin
               sh = {sh[6:0], sda_v};
               bitn++;
            end
         end else if (in_frame && !scl_v && prev_scl) begin
            if (ack_phase) begin
               ack_phase = 1'b0;
               slave_low = 1'b0;
            end else if (bitn == 8) begin
               cur = {cur[15:0], sh};
               byte_i++;
               bitn = 0;
               ack_phase = 1'b1;
               nack = (byte_i == 1) &&
                      (sh != 8'h34 || sl_nack_all || frames_started <= sl_nack_first);
               slave_low = !nack;
            end
         end
         prev_scl = scl_v;
         prev_sda = sda_v;
      end
   end

   initial forever begin
      @(negedge clk);
      if (wr_ack === 1'b1) ack_cnt++;
   end

   // ---------------- reference model: which frames appear on the bus
   logic [15:0] ents[$];
   logic [23:0] exp_f[$];
   int          exp_n[$];
   int          exp_nacks;
   bit          exp_err;

   task automatic model(input int nack_first, input bit nack_all);
      int fidx, att_max;
      fidx = 0;
      att_max = RETRY_EN ? MAX_RETRY + 1 : 1;
      exp_f.delete(); exp_n.delete(); exp_nacks = 0; exp_err = 1'b0;
      foreach (ents[e]) begin
         for (int a = 0; a < att_max; a++) begin
            fidx++;
            if (nack_all || fidx <= nack_first) begin
               exp_f.push_back(24'h000034);
               exp_n.push_back(1);
               exp_nacks++;
               if (a == att_max - 1) exp_err = 1'b1;
            end else begin
               exp_f.push_back({8'h34, ents[e]});
               exp_n.push_back(3);
               break;
            end
         end
      end
      if (exp_nacks > 255) exp_nacks = 255;
   endtask

   function automatic int first_diff();
      int n;
      n = (cap_q.size() < exp_f.size()) ? cap_q.size() : exp_f.size();
      for (int i = 0; i < n; i++)
         if (cap_q[i] !== exp_f[i] || capn_q[i] != exp_n[i]) return i;
      if (cap_q.size() != exp_f.size()) return n;
      return -1;
   endfunction

   task automatic clear_slave();
      cap_q.delete(); capn_q.delete(); frames_started = 0;
   endtask

   task automatic apply_reset(input int nack_first, input bit nack_all);
      @(negedge clk);
      reset_n = 1'b0; slave_rst = 1'b1; wr_req = 1'b0;
      repeat (3) @(negedge clk);
      clear_slave();
      sl_nack_first = nack_first; sl_nack_all = nack_all;
      for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
      slave_rst = 1'b0; ack_cnt = 0;
      reset_n = 1'b1;
   endtask

   task automatic wait_init(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (init_done === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   // called at a falling edge; returns at the falling edge where wr_ack is seen
   task automatic do_write(input logic [6:0] r, input logic [8:0] d, input bit drop, output bit got);
      got = 1'b0;
      wr_reg = r; wr_data = d; wr_req = 1'b1;
      for (int i = 0; i < 8000; i++) begin
         @(negedge clk);
         if (wr_ack === 1'b1) begin got = 1'b1; break; end
      end
      if (drop) wr_req = 1'b0;
   endtask

   // ---------------- scenarios
   task automatic test_reset();
      rom[0] = 16'h1E00; rom[1] = 16'h0C00;
      repeat (3) @(negedge clk);
      checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b want 1", sclk); end
      checks++; if (sdat !== 1'b1) begin errors++; $display("FAIL reset_sdat_released: got %b want 1", sdat); end
      checks++; if (rom_addr !== 4'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
      checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL reset_wr_ack: got %b want 0", wr_ack); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
      checks++; if (nack_count !== 8'd0) begin errors++; $display("FAIL reset_nack_count: got %0d want 0", nack_count); end
   endtask

   task automatic test_init();
      bit ok; int d;
      clear_slave();
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL init_busy_early: got %b want 1", busy); end
      wait_init(ok);
      checks++; if (!ok) begin errors++; $display("FAIL init_timeout: init_done=%b want 1", init_done); end
      repeat (4) @(negedge clk);
      ents.delete(); ents.push_back(16'h1E00); ents.push_back(16'h0C00);
      model(0, 1'b0);
      d = first_diff();
      checks++; if (d >= 0) begin errors++;
         $display("FAIL init_frames: at %0d got %h (%0d frames) want %h (%0d frames)", d, cap_q[d], cap_q.size(), exp_f[d], exp_f.size()); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL init_error: got %b want 0", error); end
      checks++; if (nack_count !== 8'd0) begin errors++; $display("FAIL init_nack_count: got %0d want 0", nack_count); end
      checks++; if (ack_cnt != 0) begin errors++; $display("FAIL init_no_wr_ack: got %0d pulses want 0", ack_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_runtime();
      bit got; int d, a0;
      logic [6:0] r; logic [8:0] v;
      clear_slave(); ents.delete();
      for (int k = 0; k < 4; k++) begin
         r = (k == 0) ? 7'h02 : 7'($urandom);
         v = (k == 0) ? 9'h17B : 9'($urandom);
         ents.push_back({r, v});
         a0 = ack_cnt;
         @(negedge clk);
         do_write(r, v, 1'b1, got);
         checks++; if (!got) begin errors++; $display("FAIL rt_ack_seen[%0d]: no wr_ack within budget", k); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rt_busy_low[%0d]: got %b want 0", k, busy); end
         repeat (30) @(negedge clk);
         checks++; if (ack_cnt - a0 != 1) begin errors++; $display("FAIL rt_one_ack[%0d]: got %0d pulses want 1", k, ack_cnt - a0); end
      end
      model(0, 1'b0);
      d = first_diff();
      checks++; if (d >= 0) begin errors++;
         $display("FAIL rt_frames: at %0d got %h (%0d frames) want %h (%0d frames)", d, cap_q[d], cap_q.size(), exp_f[d], exp_f.size()); end
   endtask

   task automatic test_back_to_back();
      bit g1, g2; int d, a0;
      logic [6:0] r1, r2; logic [8:0] v1, v2;
      r1 = 7'($urandom); v1 = 9'($urandom); r2 = 7'($urandom); v2 = 9'($urandom);
      clear_slave(); ents.delete(); ents.push_back({r1, v1}); ents.push_back({r2, v2});
      a0 = ack_cnt;
      @(negedge clk);
      do_write(r1, v1, 1'b0, g1);
      do_write(r2, v2, 1'b1, g2);
      repeat (30) @(negedge clk);
      checks++; if (!(g1 && g2)) begin errors++; $display("FAIL b2b_acks_seen: got %b%b want 11", g1, g2); end
      checks++; if (ack_cnt - a0 != 2) begin errors++; $display("FAIL b2b_ack_count: got %0d want 2", ack_cnt - a0); end
      model(0, 1'b0);
      d = first_diff();
      checks++; if (d >= 0) begin errors++;
         $display("FAIL b2b_frames: at %0d got %h (%0d frames) want %h (%0d frames)", d, cap_q[d], cap_q.size(), exp_f[d], exp_f.size()); end
   endtask

   task automatic test_reset_mid_frame();
      bit ok, hit; int d;
      apply_reset(0, 1'b0);
      hit = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (byte_i == 1 && bitn >= 3) begin hit = 1'b1; break; end
      end
      checks++; if (!hit) begin errors++; $display("FAIL midrst_reach_byte2: second byte not reached"); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL midrst_sclk: got %b want 1", sclk); end
      checks++; if (sdat !== 1'b1) begin errors++; $display("FAIL midrst_sdat: got %b want 1", sdat); end
      checks++; if (busy !== 1'b0 || rom_addr !== 4'd0) begin errors++;
         $display("FAIL midrst_state: busy=%b rom_addr=%0d want 0/0", busy, rom_addr); end
      slave_rst = 1'b1;
      repeat (3) @(negedge clk);
      clear_slave(); slave_rst = 1'b0;
      reset_n = 1'b1;
      wait_init(ok);
      repeat (4) @(negedge clk);
      checks++; if (!ok) begin errors++; $display("FAIL midrst_init_timeout: init_done=%b want 1", init_done); end
      ents.delete(); ents.push_back(rom[0]); ents.push_back(rom[1]);
      model(0, 1'b0);
      d = first_diff();
      checks++; if (d >= 0) begin errors++;
         $display("FAIL midrst_replay: at %0d got %h (%0d frames) want %h (%0d frames)", d, cap_q[d], cap_q.size(), exp_f[d], exp_f.size()); end
   endtask

   task automatic test_req_before_init();
      bit got; int d;
      logic [6:0] r; logic [8:0] v;
      r = 7'($urandom); v = 9'($urandom);
      apply_reset(0, 1'b0);
      do_write(r, v, 1'b1, got);
      checks++; if (!got) begin errors++; $display("FAIL early_req_ack: no wr_ack within budget"); end
      checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL early_req_init_first: init_done=%b at wr_ack want 1", init_done); end
      repeat (40) @(negedge clk);
      checks++; if (ack_cnt != 1) begin errors++; $display("FAIL early_req_one_ack: got %0d want 1", ack_cnt); end
      ents.delete(); ents.push_back(rom[0]); ents.push_back(rom[1]); ents.push_back({r, v});
      model(0, 1'b0);
      d = first_diff();
      checks++; if (d >= 0) begin errors++;
         $display("FAIL early_req_order: at %0d got %h (%0d frames) want %h (%0d frames)", d, cap_q[d], cap_q.size(), exp_f[d], exp_f.size()); end
   endtask

   task automatic test_nack_retry();
      bit ok; int d;
      apply_reset(2, 1'b0);
      wait_init(ok);
      repeat (4) @(negedge clk);
      checks++; if (!ok) begin errors++; $display("FAIL nack2_init_timeout: init_done=%b want 1", init_done); end
      ents.delete(); ents.push_back(rom[0]); ents.push_back(rom[1]);
      model(2, 1'b0);
      d = first_diff();
      checks++; if (d >= 0) begin errors++;
         $display("FAIL nack2_frames: at %0d got %h (%0d frames) want %h (%0d frames)", d, cap_q[d], cap_q.size(), exp_f[d], exp_f.size()); end
      checks++; if (nack_count !== 8'(exp_nacks)) begin errors++; $display("FAIL nack2_count: got %0d want %0d", nack_count, exp_nacks); end
      checks++; if (error !== exp_err) begin errors++; $display("FAIL nack2_error: got %b want %b", error, exp_err); end
   endtask

   task automatic test_always_nack();
      bit ok, got; int d;
      logic [6:0] r; logic [8:0] v;
      r = 7'($urandom); v = 9'($urandom);
      apply_reset(0, 1'b1);
      wait_init(ok);
      checks++; if (!ok) begin errors++; $display("FAIL nackall_init_timeout: init_done=%b want 1", init_done); end
      do_write(r, v, 1'b1, got);
      checks++; if (!got) begin errors++; $display("FAIL nackall_wr_ack: no wr_ack within budget"); end
      repeat (30) @(negedge clk);
      ents.delete(); ents.push_back(rom[0]); ents.push_back(rom[1]); ents.push_back({r, v});
      model(0, 1'b1);
      d = first_diff();
      checks++; if (d >= 0) begin errors++;
         $display("FAIL nackall_frames: at %0d got %h (%0d frames) want %h (%0d frames)", d, cap_q[d], cap_q.size(), exp_f[d], exp_f.size()); end
      checks++; if (nack_count !== 8'(exp_nacks)) begin errors++; $display("FAIL nackall_count: got %0d want %0d", nack_count, exp_nacks); end
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL nackall_error: got %b want 1", error); end
      checks++; if (ack_cnt != 1) begin errors++; $display("FAIL nackall_one_ack: got %0d want 1", ack_cnt); end
   endtask

   initial begin
      test_reset();
      test_init();
      test_runtime();
      test_back_to_back();
      test_reset_mid_frame();
      test_req_before_init();
      test_nack_retry();
      test_always_nack();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
